seqgen_framer_tx: RTL and testbench
===================================

Name: seqgen_framer_tx

Overview:
- Serial frame transmitter: the generating end of the serial sync-pattern link.
- Accepts a parallel payload word over a valid/ready handshake.
- Emits SYNC_PATTERN MSB-first on one serial line, then the payload MSB-first, then forced idle zeros.
- Line output feeds the team's serial sync-pattern detector (10101 marker) directly, bit-per-clock or paced by a bit strobe.

Parameters:
- DATA_WIDTH, 8, payload bits per frame (>=1).
- SYNC_LEN, 5, sync marker length in bits (>=1).
- SYNC_PATTERN, 5'b10101, marker sent MSB first; width SYNC_LEN.
- IDLE_GAP, 2, minimum zero bit-times between frames (>=1).

Ports:
- clock  input  1  single system clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- bit_enable  input  1  bit-time strobe; line advances only on edges where high; tie to 1 for one bit per clock.
- data_in  input  DATA_WIDTH  payload word.
- data_valid  input  1  payload offered.
- data_ready  output  1  transmitter can accept (combinational).
- serial_bit  output  1  registered serial line.
- frame_active  output  1  high while sync or payload bits are on the line.
- tx_done  output  1  one-cycle pulse after the last payload bit-time completes.
- present_state  output  2  FSM state for debug: 00 IDLE, 01 SYNC, 10 DATA, 11 GAP.

Behaviour:
- Reset state: IDLE, serial_bit=0, frame_active=0, tx_done=0, counters 0, shift register 0. Reset exits straight to IDLE with the gap treated as satisfied.
- data_ready = (state==IDLE) & bit_enable. Accept = data_valid & data_ready.
- data_in is sampled only on the accept edge; later changes are ignored.
- Accept edge, IDLE->SYNC:
  - serial_bit <= SYNC_PATTERN[SYNC_LEN-1]; frame_active <= 1; index <= 0; data_in loaded into shift register.
  - Latency: first line bit is visible the cycle after accept.
- SYNC: each bit_enable edge presents the next marker bit.
  - After SYNC_LEN bit-times, the same edge moves to DATA and presents data_in[DATA_WIDTH-1].
- DATA: each bit_enable edge shifts the next bit, MSB first.
  - After DATA_WIDTH bit-times, that edge moves to GAP with serial_bit <= 0, frame_active <= 0, tx_done <= 1 for exactly one clock.
- GAP: serial_bit held 0 for IDLE_GAP bit-times, counted on bit_enable edges, then -> IDLE.
  - IDLE also drives 0, so the effective gap is >= IDLE_GAP.
- bit_enable low: all state, counters and serial_bit hold; tx_done still self-clears after one clock.
- Frame length: SYNC_LEN+DATA_WIDTH bit-times; minimum frame-to-frame period: SYNC_LEN+DATA_WIDTH+IDLE_GAP+1 bit-times.
- data_valid held high outside IDLE is not accepted and causes no side effect.
- Reset mid-frame: abort; next cycle serial_bit=0, state IDLE, partial frame dropped, tx_done not pulsed.
- Payloads that contain the marker are not escaped; guarding against false detection is the system's responsibility.
- Counter widths: clog2 of max(SYNC_LEN, DATA_WIDTH, IDLE_GAP)+1; no wrap occurs inside a state.

Decomposition:
- Shared package seqgen_pkg:
  - 2-bit state localparams (IDLE/SYNC/DATA/GAP).
  - Default SYNC_PATTERN/SYNC_LEN constants, so the detector and transmitter agree on the marker.
- One sub-module, seqgen_piso:
  - Parallel-in serial-out shift register, WIDTH parameter.
  - Inputs: load, shift enable. Output: MSB.
  - Used twice: once for the marker, once for the payload.
- FSM and counters stay in the top module.

Test Plan:
- bit_enable=1, accept data_in=8'hA5 at cycle 0 -> serial_bit cycles 1..13 = 1,0,1,0,1, 1,0,1,0,0,1,0,1. frame_active high cycles 1..13. tx_done pulse cycle 14. data_ready low until the GAP completes (IDLE at cycle 16).
- Loopback: serial_bit into the 10101 detector, send 8'h00 -> detector output_indicator pulses exactly once, aligned with the 5th marker bit.
- bit_enable high every 4th clock, send 8'hFF -> each line bit held exactly 4 clocks. tx_done width still 1 clock.
- data_valid held high with 8'h3C then 8'hC3 -> second word accepted only on the first IDLE+bit_enable edge after 2 zero bit-times. Both frames correct on the line.
- Reset asserted at the 3rd payload bit -> next cycle serial_bit=0, present_state=00, no tx_done. A new frame after reset is transmitted intact.
- data_in changed right after accept -> transmitted payload equals the value sampled at accept.

Source files
------------

// File: rtl/seqgen_pkg.sv
// Shared definitions for the serial sync-pattern link: FSM encodings and the
// default marker, so transmitter and detector agree on the same pattern.
package seqgen_pkg;

  localparam logic [1:0] ST_IDLE = 2'b00;
  localparam logic [1:0] ST_SYNC = 2'b01;
  localparam logic [1:0] ST_DATA = 2'b10;
  localparam logic [1:0] ST_GAP  = 2'b11;

  localparam int             SYNC_LEN_DEF     = 5;
  localparam logic [4:0]     SYNC_PATTERN_DEF = 5'b10101;

  function automatic int max3(input int a, input int b, input int c);
    int m;
    m = (a > b) ? a : b;
    return (m > c) ? m : c;
  endfunction

endpackage

// File: rtl/seqgen_piso.sv
// Parallel-in serial-out shift register; MSB is presented, shifts toward MSB.
module seqgen_piso #(
  parameter int WIDTH = 8
)(
  input  logic             clock,
  input  logic             reset,
  input  logic             load_i,
  input  logic [WIDTH-1:0] data_i,
  input  logic             shift_i,
  output logic             msb_o
);

  logic [WIDTH-1:0] sr_q, sr_d;

  always_comb begin
    sr_d = sr_q;
    if (load_i)
      sr_d = data_i;
    else if (shift_i)
      sr_d = sr_q << 1;
  end

  always_ff @(posedge clock) begin
    if (reset) sr_q <= '0;
    else       sr_q <= sr_d;
  end

  assign msb_o = sr_q[WIDTH-1];

endmodule

// File: rtl/seqgen_framer_tx.sv
// Serial frame transmitter: sync marker MSB-first, payload MSB-first, then a
// forced zero gap. The line advances only on bit_enable edges.
module seqgen_framer_tx
  import seqgen_pkg::*;
#(
  parameter int                  DATA_WIDTH   = 8,
  parameter int                  SYNC_LEN     = SYNC_LEN_DEF,
  parameter logic [SYNC_LEN-1:0] SYNC_PATTERN = SYNC_PATTERN_DEF,
  parameter int                  IDLE_GAP     = 2
)(
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  bit_enable,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic                  data_valid,
  output logic                  data_ready,
  output logic                  serial_bit,
  output logic                  frame_active,
  output logic                  tx_done,
  output logic [1:0]            present_state
);

  localparam int CW = $clog2(max3(SYNC_LEN, DATA_WIDTH, IDLE_GAP) + 1);
  // The marker MSB goes straight to the line on accept, so the marker
  // register starts with it already consumed.
  localparam logic [SYNC_LEN-1:0] MARK_REST = SYNC_PATTERN << 1;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          serial_q, serial_d;
  logic          active_q, active_d;
  logic          done_q, done_d;
  logic          accept, mark_shift, data_shift, mark_msb, data_msb;

  assign data_ready = (state_q == ST_IDLE) && bit_enable;
  assign accept     = data_valid && data_ready;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    serial_d   = serial_q;
    active_d   = active_q;
    done_d     = 1'b0;
    mark_shift = 1'b0;
    data_shift = 1'b0;
    if (bit_enable) begin
      case (state_q)
        ST_IDLE: begin
          serial_d = 1'b0;
          if (accept) begin
            state_d  = ST_SYNC;
            serial_d = SYNC_PATTERN[SYNC_LEN-1];
            active_d = 1'b1;
            cnt_d    = '0;
          end
        end
        ST_SYNC: begin
          if (cnt_q == CW'(SYNC_LEN - 1)) begin
            state_d    = ST_DATA;
            serial_d   = data_msb;
            data_shift = 1'b1;
            cnt_d      = '0;
          end else begin
            serial_d   = mark_msb;
            mark_shift = 1'b1;
            cnt_d      = cnt_q + 1'b1;
          end
        end
        ST_DATA: begin
          if (cnt_q == CW'(DATA_WIDTH - 1)) begin
            state_d  = ST_GAP;
            serial_d = 1'b0;
            active_d = 1'b0;
            done_d   = 1'b1;
            cnt_d    = '0;
          end else begin
            serial_d   = data_msb;
            data_shift = 1'b1;
            cnt_d      = cnt_q + 1'b1;
          end
        end
        default: begin
          serial_d = 1'b0;
          if (cnt_q == CW'(IDLE_GAP - 1)) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      serial_q <= 1'b0;
      active_q <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      serial_q <= serial_d;
      active_q <= active_d;
      done_q   <= done_d;
    end
  end

  seqgen_piso #(.WIDTH(SYNC_LEN)) u_mark (
    .clock   (clock),
    .reset   (reset),
    .load_i  (accept),
    .data_i  (MARK_REST),
    .shift_i (mark_shift),
    .msb_o   (mark_msb)
  );

  seqgen_piso #(.WIDTH(DATA_WIDTH)) u_data (
    .clock   (clock),
    .reset   (reset),
    .load_i  (accept),
    .data_i  (data_in),
    .shift_i (data_shift),
    .msb_o   (data_msb)
  );

  assign serial_bit    = serial_q;
  assign frame_active  = active_q;
  assign tx_done       = done_q;
  assign present_state = state_q;

endmodule

// File: tb/tb_seqgen_framer_tx.sv
// Directed bench for seqgen_framer_tx with default parameters (8-bit payload,
// 10101 marker, 2 bit-time gap).
module tb_seqgen_framer_tx;

  logic       clock = 1'b0;
  logic       reset;
  logic       bit_enable;
  logic [7:0] data_in;
  logic       data_valid;
  logic       data_ready;
  logic       serial_bit;
  logic       frame_active;
  logic       tx_done;
  logic [1:0] present_state;

  int checks   = 0;
  int failures = 0;

  seqgen_framer_tx dut (
    .clock         (clock),
    .reset         (reset),
    .bit_enable    (bit_enable),
    .data_in       (data_in),
    .data_valid    (data_valid),
    .data_ready    (data_ready),
    .serial_bit    (serial_bit),
    .frame_active  (frame_active),
    .tx_done       (tx_done),
    .present_state (present_state)
  );

  always #5 clock = ~clock;

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // Sends one word from IDLE with bit_enable=1 and captures the 13 line bits
  // (MSB = first bit). Returns at cycle 16, back in IDLE.
  task automatic run_frame(input logic [7:0] d, output logic [12:0] bits,
                           output logic done_seen);
    data_in    = d;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int c = 0; c < 13; c++) begin
      bits[12-c] = serial_bit;
      tick();
    end
    done_seen = tx_done;
    tick();
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick();
    tick();
    checks++;
    if ({serial_bit, frame_active, tx_done, present_state} !== 5'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=00000",
               {serial_bit, frame_active, tx_done, present_state});
    end
    reset = 1'b0;
    tick();
    checks++;
    if (data_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready got=%b want=1", data_ready);
    end
  endtask

  task automatic test_basic();
    logic [12:0] exp;
    exp = 13'b10101_10100101;
    data_in    = 8'hA5;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      if (c <= 13) begin
        checks++;
        if (serial_bit !== exp[13-c] || frame_active !== 1'b1 || tx_done !== 1'b0) begin
          failures++;
          $display("FAIL basic_bit c=%0d got=%b/%b/%b want=%b/1/0", c,
                   serial_bit, frame_active, tx_done, exp[13-c]);
        end
      end else if (c == 14) begin
        checks++;
        if ({serial_bit, frame_active, tx_done, present_state} !== 5'b00111) begin
          failures++;
          $display("FAIL basic_done got=%b want=00111",
                   {serial_bit, frame_active, tx_done, present_state});
        end
      end else if (c == 15) begin
        checks++;
        if (tx_done !== 1'b0 || present_state !== 2'b11) begin
          failures++;
          $display("FAIL basic_gap got=%b/%b want=0/11", tx_done, present_state);
        end
      end
      if (c <= 15) begin
        checks++;
        if (data_ready !== 1'b0) begin
          failures++;
          $display("FAIL basic_ready_low c=%0d got=%b want=0", c, data_ready);
        end
      end else begin
        checks++;
        if (present_state !== 2'b00 || data_ready !== 1'b1) begin
          failures++;
          $display("FAIL basic_idle got=%b/%b want=00/1", present_state, data_ready);
        end
      end
      if (c < 16) tick();
    end
  endtask

  task automatic test_loopback();
    logic [4:0] det;
    int hits, hit_c;
    det = 5'b0; hits = 0; hit_c = -1;
    data_in    = 8'h00;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      det = {det[3:0], serial_bit};
      if (det == 5'b10101) begin
        hits++;
        hit_c = c;
      end
      if (c < 16) tick();
    end
    checks++;
    if (hits != 1 || hit_c != 5) begin
      failures++;
      $display("FAIL loopback got hits=%0d at=%0d want hits=1 at=5", hits, hit_c);
    end
  endtask

  task automatic test_paced();
    logic [12:0] exp;
    logic        eb;
    int          pulses;
    exp = 13'b10101_11111111;
    pulses = 0;
    data_in = 8'hFF;
    for (int n = 0; n < 64; n++) begin
      bit_enable = (n % 4 == 0);
      data_valid = (n == 0);
      tick();
      eb = (n < 52) ? exp[12 - n/4] : 1'b0;
      checks++;
      if (serial_bit !== eb) begin
        failures++;
        $display("FAIL paced_bit n=%0d got=%b want=%b", n, serial_bit, eb);
      end
      checks++;
      if (tx_done !== (n == 52)) begin
        failures++;
        $display("FAIL paced_done n=%0d got=%b want=%b", n, tx_done, (n == 52));
      end
      if (tx_done === 1'b1) pulses++;
    end
    checks++;
    if (pulses != 1 || present_state !== 2'b00) begin
      failures++;
      $display("FAIL paced_end got pulses=%0d st=%b want 1/00", pulses, present_state);
    end
    bit_enable = 1'b1;
    data_valid = 1'b0;
    tick();
  endtask

  task automatic test_back_to_back();
    logic [28:0] exp;
    exp = {5'b10101, 8'h3C, 3'b000, 5'b10101, 8'hC3};
    data_in    = 8'h3C;
    data_valid = 1'b1;
    tick();
    data_in = 8'hC3;
    for (int c = 1; c <= 29; c++) begin
      checks++;
      if (serial_bit !== exp[29-c]) begin
        failures++;
        $display("FAIL b2b_bit c=%0d got=%b want=%b", c, serial_bit, exp[29-c]);
      end
      if (c == 16) begin
        checks++;
        if (data_ready !== 1'b1) begin
          failures++;
          $display("FAIL b2b_ready c=16 got=%b want=1", data_ready);
        end
      end
      if (c == 15) begin
        checks++;
        if (data_ready !== 1'b0) begin
          failures++;
          $display("FAIL b2b_early c=15 got=%b want=0", data_ready);
        end
      end
      if (c == 17) begin
        data_valid = 1'b0;
        checks++;
        if (present_state !== 2'b01) begin
          failures++;
          $display("FAIL b2b_state c=17 got=%b want=01", present_state);
        end
      end
      if (c < 29) tick();
    end
    for (int i = 0; i < 3; i++) tick();
  endtask

  task automatic test_sample_hold();
    logic [12:0] bits;
    logic        dn;
    data_in    = 8'h5A;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    data_in    = 8'hFF;
    bits[12] = serial_bit;
    for (int c = 1; c < 13; c++) begin
      tick();
      bits[12-c] = serial_bit;
    end
    tick();
    dn = tx_done;
    tick();
    tick();
    checks++;
    if (bits !== {5'b10101, 8'h5A} || dn !== 1'b1) begin
      failures++;
      $display("FAIL sample_hold got=%b/%b want=%b/1", bits, dn, {5'b10101, 8'h5A});
    end
  endtask

  task automatic test_reset_midframe();
    logic [12:0] bits;
    logic        dn;
    int          stray;
    stray = 0;
    data_in    = 8'hFF;
    data_valid = 1'b1;
    tick();
    data_valid = 1'b0;
    for (int i = 0; i < 7; i++) tick();
    checks++;
    if (serial_bit !== 1'b1 || present_state !== 2'b10) begin
      failures++;
      $display("FAIL midreset_pre got=%b/%b want=1/10", serial_bit, present_state);
    end
    reset = 1'b1;
    tick();
    checks++;
    if ({serial_bit, frame_active, tx_done, present_state} !== 5'b0) begin
      failures++;
      $display("FAIL midreset_abort got=%b want=00000",
               {serial_bit, frame_active, tx_done, present_state});
    end
    reset = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      if (tx_done !== 1'b0 || serial_bit !== 1'b0) stray++;
    end
    checks++;
    if (stray != 0) begin
      failures++;
      $display("FAIL midreset_quiet got=%0d want=0", stray);
    end
    run_frame(8'h96, bits, dn);
    checks++;
    if (bits !== {5'b10101, 8'h96} || dn !== 1'b1) begin
      failures++;
      $display("FAIL midreset_next got=%b/%b want=%b/1", bits, dn, {5'b10101, 8'h96});
    end
  endtask

  initial begin
    reset      = 1'b1;
    bit_enable = 1'b1;
    data_in    = 8'h00;
    data_valid = 1'b0;
    test_reset();
    test_basic();
    test_loopback();
    test_paced();
    test_back_to_back();
    test_sample_hold();
    test_reset_midframe();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
